flash_loader: RTL and testbench
===============================

# flash_loader

Byte-stream boot loader that drives the program memory's flash port (`flash_en`, `flash_addr`, `flash_data`). It accepts a length-prefixed, checksummed little-endian byte stream over a valid/ready handshake from a host link, for example a UART receiver. It assembles the bytes into WIDTH-bit words and issues one single-cycle flash write per word at consecutive word-aligned byte addresses. The CPU is held off while `busy` is high.

## Interface
- `WIDTH`, default 32: data and address width. Must be 32: four bytes per word.
- `ADDR_BASE`, default 0: byte address of the first word written. Must be word-aligned.
- `MAX_WORDS`, default 2048: largest accepted word count (memory depth, 11-bit word address).

Ports:
- `clk` input 1: single clock.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERROR.
- `in_valid` input 1: `in_data` is valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: the loader accepts a byte this cycle.
- `flash_en` output 1: one-cycle memory write strobe.
- `flash_addr` output WIDTH: byte address of the write.
- `flash_data` output WIDTH: word to write.
- `busy` output 1: a load is in progress (any state other than IDLE, DONE or ERROR).
- `done` output 1: sticky. The last load completed with a good checksum.
- `error` output 1: sticky. The last load was aborted because the length exceeded `MAX_WORDS` or the checksum mismatched.

## Operation
- Byte transfer: a byte transfers on any cycle with `in_valid && in_ready`. `in_data` is ignored otherwise.
- Stream format:
  - N: 16-bit word count, little-endian, 2 bytes.
  - Data: 4·N bytes. Each word is little-endian, so the first byte goes to bits [7:0].
  - Checksum: 1 byte, equal to the XOR of all 4·N data bytes. The length bytes are excluded, so N=0 has checksum 0x00.
- State machine, states IDLE, LEN0, LEN1, DATA, WRITE, CHECK, DONE, ERROR:
  - IDLE/DONE/ERROR → LEN0 on `start`. This clears `done`, `error`, the word index, the byte index and the checksum accumulator.
  - LEN0 → LEN1 on a transfer. The byte latches as N[7:0].
  - LEN1 → on a transfer, the byte latches as N[15:8], then:
    - N > `MAX_WORDS`: go to ERROR.
    - N == 0: go to CHECK.
    - Otherwise: go to DATA.
  - DATA: each transfer shifts the byte into the word register at lane `byte_idx`, XORs it into the accumulator and increments the 2-bit `byte_idx`. The transfer that completes the fourth byte goes to WRITE.
  - WRITE: lasts one cycle. `flash_en`=1, `flash_addr` = `ADDR_BASE` + 4·`word_idx`, `flash_data` = the assembled word. Then `word_idx` increments and the state goes to CHECK if `word_idx`+1 == N, else to DATA.
  - CHECK: on a transfer, go to DONE if the byte equals the accumulator, else to ERROR.
  - DONE/ERROR: hold until `start` or `rst`.
- `in_ready` = 1 only in LEN0, LEN1, DATA and CHECK. It is 0 in WRITE, so no byte can arrive during a flash write.
- `flash_en` = 1 only in WRITE. `flash_addr` and `flash_data` are 0 whenever `flash_en` = 0.
- Writes already issued are not undone on a checksum error. Software reloads.
- `start` while `busy` is ignored.
- Simultaneous `start` and `rst`: `rst` wins.

## Timing
- Reset: state IDLE. `in_ready`, `flash_en`, `flash_addr`, `flash_data`, `busy`, `done` and `error` are all 0. Internal counters and the accumulator are 0.
- `rst` mid-load aborts immediately. No `flash_en` is issued after the reset cycle and partial words are discarded.
- `busy` rises the cycle after `start` and falls the cycle the FSM enters DONE or ERROR.
- `flash_en` asserts exactly one cycle, the cycle after the fourth byte of a word transfers. The minimum cost is 5 cycles per word at full input rate.
- `done` or `error` rises the cycle after the checksum byte transfers. For an oversize length, `error` rises the cycle after the second length byte.
- `in_valid` gaps stall the FSM with no state change and no timeout.
- Arithmetic:
  - `word_idx` is 16 bits wide.
  - Address arithmetic is WIDTH bits wide, with no wrap check beyond the `MAX_WORDS` limit.
  - N == `MAX_WORDS` is legal. N == `MAX_WORDS`+1 is an error.

## Test plan
- Single word: `start`, then bytes 01 00 78 56 34 12 08 → one `flash_en` pulse with `flash_addr`=0x0 and `flash_data`=0x12345678. `done`=1 and `error`=0 one cycle after byte 08.
- Three words with random `in_valid` gaps, words 0x11111111, 0x22222222, 0x33333333, checksum 0x00 → exactly three `flash_en` pulses at addresses 0x0, 0x4, 0x8 with matching data. `in_ready`=0 during every WRITE cycle. `done`=1.
- Empty load: bytes 00 00 00 → no `flash_en` pulse, `done`=1.
- Bad checksum: the single-word stream with checksum 0xFF → one write at 0x0 still occurs, then `error`=1, `done`=0, `busy`=0.
- Oversize length: bytes 01 08 (N=2049) → `error`=1 the cycle after the second byte, no `flash_en` pulse, `in_ready`=0. A subsequent `start` with a valid stream succeeds and clears `error`.
- Reset mid-load: assert `rst` after the second word's WRITE → the next cycle has all outputs 0 and state IDLE, and no further `flash_en` pulse appears. A fresh `start` with the single-word stream writes 0x12345678 at 0x0.

Source files
------------

// File: rtl/flash_loader.sv
`default_nettype none
// ============================================================================
// flash_loader
//   Length-prefixed, XOR-checksummed byte stream to word-wide flash writes.
//   Revision 1.0
// ============================================================================
module flash_loader #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BASE = 0,
    parameter int MAX_WORDS = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             flash_en,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    localparam logic [16:0]      c_max_words = 17'(MAX_WORDS);
    localparam logic [WIDTH-1:0] c_base      = WIDTH'(ADDR_BASE);

    state_t       r_state;
    logic [15:0]  r_len;
    logic [15:0]  r_word_idx;
    logic [1:0]   r_byte_idx;
    logic [7:0]   r_acc;
    logic [23:0]  r_word;
    logic         w_xfer;

    assign w_xfer = in_valid && in_ready;

    // Outputs are registered: each transition also sets the outputs of the
    // state being entered, so in_ready always matches the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_acc      <= '0;
            r_word     <= '0;
            in_ready   <= 1'b0;
            flash_en   <= 1'b0;
            flash_addr <= '0;
            flash_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            flash_en   <= 1'b0;
            flash_addr <= '0;
            flash_data <= '0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_LEN0;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_acc      <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        in_ready   <= 1'b1;
                    end
                end
                S_LEN0: begin
                    if (w_xfer) begin
                        r_len[7:0] <= in_data;
                        r_state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_xfer) begin
                        r_len[15:8] <= in_data;
                        if ({1'b0, in_data, r_len[7:0]} > c_max_words) begin
                            r_state  <= S_ERROR;
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else if ({in_data, r_len[7:0]} == 16'd0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_acc      <= r_acc ^ in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= in_data;
                            2'd1: r_word[15:8]  <= in_data;
                            2'd2: r_word[23:16] <= in_data;
                            default: begin
                                r_state    <= S_WRITE;
                                in_ready   <= 1'b0;
                                flash_en   <= 1'b1;
                                flash_addr <= c_base + WIDTH'({r_word_idx, 2'b00});
                                flash_data <= WIDTH'({in_data, r_word});
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_word_idx <= r_word_idx + 16'd1;
                    in_ready   <= 1'b1;
                    if (r_word_idx + 16'd1 == r_len) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == r_acc) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            error   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_loader.sv
`default_nettype none
// ============================================================================
// tb_flash_loader
//   Randomised stream loads against a byte-stream reference model.
//   Revision 1.0
// ============================================================================
module tb_flash_loader;

    localparam int WIDTH     = 32;
    localparam int ADDR_BASE = 0;
    localparam int MAX_WORDS = 2048;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        flash_en;
    logic [31:0] flash_addr;
    logic [31:0] flash_data;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    flash_loader #(
        .WIDTH    (WIDTH),
        .ADDR_BASE(ADDR_BASE),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flash_en  (flash_en),
        .flash_addr(flash_addr),
        .flash_data(flash_data),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bq_t make_stream(input wq_t words, input bit bad_ck);
        bq_t        s;
        int         n;
        logic [7:0] x;
        logic [7:0] b;
        n = words.size();
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        x = 8'h00;
        foreach (words[i]) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(words[i] >> (8 * k));
                s.push_back(b);
                x = x ^ b;
            end
        end
        s.push_back(bad_ck ? ~x : x);
        return s;
    endfunction

    // Drives one load and checks every cycle against the model derived from
    // the stream bytes. abort_after > 0 resets the DUT after that many writes.
    task automatic run_load(input bq_t stream, input int gap_pct, input int abort_after);
        int          n;
        bit          oversize;
        bit          exp_ok;
        int          consume;
        int          idx;
        int          cycles;
        int          budget;
        int          writes;
        bit          xfer;
        logic [7:0]  x;
        logic [31:0] w;
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];

        n        = int'(stream[0]) + 256 * int'(stream[1]);
        oversize = (n > MAX_WORDS);
        exp_ok   = 1'b0;
        x        = 8'h00;
        if (oversize) begin
            consume = 2;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = 32'h0;
                for (int k = 0; k < 4; k++) begin
                    w = w | (32'(stream[2 + 4 * i + k]) << (8 * k));
                    x = x ^ stream[2 + 4 * i + k];
                end
                exp_addr.push_back(32'(ADDR_BASE + 4 * i));
                exp_data.push_back(w);
            end
            consume = 2 + 4 * n + 1;
            exp_ok  = (stream[consume - 1] == x);
        end
        budget = 3 * (consume + n) + 50;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        idx    = 0;
        cycles = 0;
        writes = 0;
        while (idx < consume && cycles < budget) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? stream[idx] : 8'($urandom);
            @(negedge clk);
            check_val("busy_in_load", busy, 1);
            check_val("flags_clear", {done, error}, 0);
            if (flash_en) begin
                check_val("ready_in_write", in_ready, 0);
                if (exp_addr.size() == 0) begin
                    check_val("extra_write", 1, 0);
                end else begin
                    check_val("write_addr", flash_addr, exp_addr.pop_front());
                    check_val("write_data", flash_data, exp_data.pop_front());
                end
                writes++;
            end else begin
                check_val("bus_idle_zero", {flash_addr, flash_data}, 0);
            end
            xfer = in_valid && in_ready;
            if (abort_after > 0 && flash_en && writes == abort_after) begin
                @(posedge clk); #1;
                rst      = 1'b1;
                in_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check_val("abort_outputs",
                          {in_ready, flash_en, flash_addr, flash_data, busy, done, error}, 0);
                for (int c = 0; c < 20; c++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b1;
                    in_data  = 8'($urandom);
                    @(negedge clk);
                    check_val("abort_quiet", {flash_en, in_ready, busy}, 0);
                end
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (xfer) idx++;
            cycles++;
        end
        in_valid = 1'b0;
        if (cycles >= budget) begin
            check_val("timeout_bytes", 64'(idx), 64'(consume));
        end
        @(negedge clk);
        check_val("end_done",   done,  (!oversize && exp_ok));
        check_val("end_error",  error, (oversize || !exp_ok));
        check_val("end_busy",   busy,  0);
        check_val("end_ready",  in_ready, 0);
        check_val("end_flash",  flash_en, 0);
        check_val("write_count", 64'(exp_addr.size()), 0);
    endtask

    initial begin
        bq_t s;
        wq_t words;
        int  nw;

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("reset_outputs",
                  {in_ready, flash_en, flash_addr, flash_data, busy, done, error}, 0);

        // single word, full rate
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run_load(s, 0, 0);

        // three words with gaps
        words = '{32'h11111111, 32'h22222222, 32'h33333333};
        s = make_stream(words, 1'b0);
        check_val("three_word_ck", s[14], 8'h00);
        run_load(s, 40, 0);

        // empty load
        s = '{8'h00, 8'h00, 8'h00};
        run_load(s, 0, 0);

        // bad checksum
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF};
        run_load(s, 0, 0);

        // oversize, then recovery
        s = '{8'h01, 8'h08};
        run_load(s, 20, 0);
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run_load(s, 0, 0);

        // reset after the second write, then a fresh load
        words = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
        s = make_stream(words, 1'b0);
        run_load(s, 30, 2);
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run_load(s, 0, 0);

        // random loads
        for (int t = 0; t < 20; t++) begin
            words.delete();
            nw = $urandom_range(6);
            for (int i = 0; i < nw; i++) words.push_back($urandom);
            s = make_stream(words, ($urandom_range(3) == 0));
            run_load(s, $urandom_range(50), 0);
        end

        // largest legal length
        words.delete();
        for (int i = 0; i < MAX_WORDS; i++) words.push_back($urandom);
        s = make_stream(words, 1'b0);
        run_load(s, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
